ld_st_cir_q_gen: RTL

- Parametrised successor to the load/store circular queue.
- Tagged FIFO that allocates entries at the issue pointer and returns the index as a tag.
- Accepts NUM_UPD broadcast updates per cycle; each update writes data and sets a per-entry done bit.
- Retires in order only when the head entry is done. Adds an occupancy count, flush and parametrised lookup ports.
- Sits between dispatch and the memory unit; holds load/store address/data entries keyed by queue index.

---
 rtl/ld_st_cir_q_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ld_st_cir_q_gen.sv
// ---------------------------------------------------------------------------
// ld_st_cir_q_gen
//
// Tagged circular queue for load/store entries. Dispatch allocates an entry at
// the tail pointer and receives that index as a tag. Any number of broadcast
// update ports can later write data into an entry and mark it done. Entries
// retire in order from the head, and only once the head is done.
//
// Build option:
//   LD_ST_CIRQ_HEAD_BYPASS_EN - when defined, an update that targets a
//   not-yet-done head entry is forwarded straight to commit_ready/commit_data
//   in the same cycle. Lookup ports never see the bypass.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              squash every entry; highest priority
//   issue/issue_data/issue_done -> issue_idx/issue_ack   allocation
//   commit -> commit_ready/commit_data/commit_idx        in-order retire
//   upd_valid/upd_idx/upd_data   NUM_UPD packed broadcast update ports
//   lkup_idx -> lkup_data/lkup_done  NUM_LKUP packed read-only lookups
//   count/full/empty   occupancy status
//
// Handshakes: issue is accepted (issue_ack) in any cycle where issue is high,
// the queue is not full and flush is low. commit is accepted in any cycle
// where commit and commit_ready are high and flush is low. Both are
// single-cycle and need no holding; a refused request has no effect.
// ---------------------------------------------------------------------------
module ld_st_cir_q_gen #(
  parameter int WIDTH    = 32,
  parameter int IDX_W    = 3,
  parameter int NUM_UPD  = 4,
  parameter int NUM_LKUP = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      issue,
  input  logic [WIDTH-1:0]          issue_data,
  input  logic                      issue_done,
  output logic [IDX_W-1:0]          issue_idx,
  output logic                      issue_ack,
  input  logic                      commit,
  output logic                      commit_ready,
  output logic [WIDTH-1:0]          commit_data,
  output logic [IDX_W-1:0]          commit_idx,
  input  logic [NUM_UPD-1:0]        upd_valid,
  input  logic [NUM_UPD*IDX_W-1:0]  upd_idx,
  input  logic [NUM_UPD*WIDTH-1:0]  upd_data,
  input  logic [NUM_LKUP*IDX_W-1:0] lkup_idx,
  output logic [NUM_LKUP*WIDTH-1:0] lkup_data,
  output logic [NUM_LKUP-1:0]       lkup_done,
  output logic [IDX_W:0]            count,
  output logic                      full,
  output logic                      empty
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic iss_acc;
  logic cmt_acc;

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign issue_idx  = tail_q;
  assign commit_idx = head_q;

  assign issue_ack  = issue & ~full & ~flush;
  assign iss_acc    = issue_ack;
  assign cmt_acc    = commit & commit_ready & ~flush;

  // -------------------------------------------------------------------------
  // Head presentation (optionally bypassed from the update ports)
  // -------------------------------------------------------------------------
`ifdef LD_ST_CIRQ_HEAD_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_data;

  // Scan ports in ascending order so the highest-numbered hitting port wins,
  // matching the priority used for the registered array write.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < NUM_UPD; i++) begin
      if (upd_valid[i] && (upd_idx[i*IDX_W +: IDX_W] == head_q)) begin
        byp_hit  = 1'b1;
        byp_data = upd_data[i*WIDTH +: WIDTH];
      end
    end
    // Only forward while the head is waiting; a done head already shows
    // its own registered data.
    byp_hit = byp_hit & occ_q[head_q] & ~done_q[head_q];
  end

  assign commit_ready = occ_q[head_q] & (done_q[head_q] | byp_hit);
  assign commit_data  = byp_hit ? byp_data : data_q[head_q];
`else
  assign commit_ready = occ_q[head_q] & done_q[head_q];
  assign commit_data  = data_q[head_q];
`endif

  // -------------------------------------------------------------------------
  // Lookups: plain reads of the registered array
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_LKUP; k++) begin : g_lkup
    logic [IDX_W-1:0] li;
    assign li                         = lkup_idx[k*IDX_W +: IDX_W];
    assign lkup_data[k*WIDTH +: WIDTH] = data_q[li];
    assign lkup_done[k]               = occ_q[li] & done_q[li];
  end

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    occ_d   = occ_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Updates: later ports overwrite earlier ones, so the highest-numbered
      // port wins. Only occupied entries accept updates, and an update to a
      // head that retires this cycle is discarded with it.
      for (int i = 0; i < NUM_UPD; i++) begin
        if (upd_valid[i] && occ_q[upd_idx[i*IDX_W +: IDX_W]] &&
            !(cmt_acc && (upd_idx[i*IDX_W +: IDX_W] == head_q))) begin
          data_d[upd_idx[i*IDX_W +: IDX_W]] = upd_data[i*WIDTH +: WIDTH];
          done_d[upd_idx[i*IDX_W +: IDX_W]] = 1'b1;
        end
      end

      if (cmt_acc) begin
        occ_d[head_q] = 1'b0;
        head_d        = head_q + 1'b1;
      end

      // The tail slot is never occupied when issue is accepted (not full),
      // so no update above can collide with this allocation.
      if (iss_acc) begin
        data_d[tail_q] = issue_data;
        done_d[tail_q] = issue_done;
        occ_d[tail_q]  = 1'b1;
        tail_d         = tail_q + 1'b1;
      end

      case ({iss_acc, cmt_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from occ_q.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule
